elevator_car_plant: RTL and testbench

- Models the elevator car and shaft on the far side of the controller interface.
- Consumes motor_up, motor_down and door_open from the controller.
- Produces current_floor and the latched floor requests req that the controller reads.
- Used as the closed-loop plant in system simulation and as the FPGA demo car model; it contains the position counter, door timer and call-button latches.

---
 rtl/elevator_pkg.sv | 7 +
 rtl/elevator_call_latch.sv | 13 +
 rtl/elevator_car_plant.sv | 94 +++++++++
 tb/tb_elevator_car_plant.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor sizing, direction and controller state encodings for the elevator slice.
package elevator_pkg;
    localparam int NUM_FLOORS_DEF = 5;
    localparam int FLOOR_W = 3;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR, ST_HOLD} ctrl_state_e;
endpackage

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: per-floor call latches, clear beats set when both hit one bit.
module elevator_call_latch #(
    parameter int NUM_FLOORS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] set,
    input  logic [NUM_FLOORS-1:0] clr,
    output logic [NUM_FLOORS-1:0] q
);
    always_ff @(posedge clk)
        q <= reset ? '0 : (q | set) & ~clr;
endmodule

// File: rtl/elevator_car_plant.sv
// elevator_car_plant: car position, door timer and call latches seen by the controller.
// Optional sticky fault detection is built when ELEV_CAR_FAULT_DETECT_EN is defined.
module elevator_car_plant
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_TICKS      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  motor_up,
    input  logic                  motor_down,
    input  logic                  door_open,
    input  logic [NUM_FLOORS-1:0] call_btn,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  at_floor,
    output logic                  moving,
    output logic                  door_closed,
    output logic [NUM_FLOORS-1:0] req,
    output logic                  fault
);
    localparam int SUB_W = $clog2(TICKS_PER_FLOOR);
    localparam int TMR_W = $clog2(DOOR_TICKS + 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_FLOOR - 1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

    logic [FLOOR_W-1:0]    floor_r, floor_n;
    logic [SUB_W-1:0]      sub, sub_n;
    logic [TMR_W-1:0]      tmr;
    logic [NUM_FLOORS-1:0] clr;
    dir_e                  dir;
    logic                  door_ok, over, legal, accept;

    always_comb begin
        dir     = (motor_up && !motor_down) ? DIR_UP : (motor_down && !motor_up) ? DIR_DOWN : DIR_NONE;
        door_ok = door_closed && !door_open;
        over    = (motor_up && floor_r == TOP && sub == '0) || (motor_down && floor_r == '0 && sub == '0);
        legal   = dir != DIR_NONE && door_ok && !over && !fault;
        floor_n = !legal ? floor_r
                : dir == DIR_UP ? (sub == SUB_MAX ? floor_r + FLOOR_W'(1) : floor_r)
                : (sub == '0 ? floor_r - FLOOR_W'(1) : floor_r);
        sub_n   = !legal ? sub
                : dir == DIR_UP ? (sub == SUB_MAX ? '0 : sub + SUB_W'(1))
                : (sub == '0 ? SUB_MAX : sub - SUB_W'(1));
        accept  = door_open && at_floor && !motor_up && !motor_down;
        clr     = accept ? NUM_FLOORS'(1) << current_floor : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            floor_r       <= '0;
            sub           <= '0;
            current_floor <= '0;
            at_floor      <= 1'b1;
            moving        <= 1'b0;
            door_closed   <= 1'b1;
            tmr           <= '0;
        end else begin
            floor_r  <= floor_n;
            sub      <= sub_n;
            at_floor <= sub_n == '0;
            moving   <= legal;
            // current_floor only follows the car once it is level again
            if (sub_n == '0)
                current_floor <= floor_n;
            if (accept) begin
                tmr         <= TMR_W'(DOOR_TICKS);
                door_closed <= 1'b0;
            end else if (tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
                if (tmr == TMR_W'(1))
                    door_closed <= 1'b1;
            end
        end
    end

`ifdef ELEV_CAR_FAULT_DETECT_EN
    logic fault_cond;
    assign fault_cond = (motor_up && motor_down) || over || ((motor_up || motor_down) && !door_ok);
    always_ff @(posedge clk)
        fault <= reset ? 1'b0 : fault | fault_cond;
`else
    assign fault = 1'b0;
`endif

    elevator_call_latch #(.NUM_FLOORS(NUM_FLOORS)) u_latch (
        .clk  (clk),
        .reset(reset),
        .set  (call_btn),
        .clr  (clr),
        .q    (req)
    );
endmodule

// File: tb/tb_elevator_car_plant.sv
// tb_elevator_car_plant: tick-position reference model feeds an expectation queue checked after each edge.
module tb_elevator_car_plant;
    localparam int NF = 5;
    localparam int T  = 8;
    localparam int DT = 4;
`ifdef ELEV_CAR_FAULT_DETECT_EN
    localparam bit FDET = 1'b1;
`else
    localparam bit FDET = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1, motor_up = 1'b0, motor_down = 1'b0, door_open = 1'b0;
    logic [NF-1:0] call_btn = '0;
    logic [2:0] current_floor;
    logic at_floor, moving, door_closed, fault;
    logic [NF-1:0] req;

    always #5 clk = ~clk;

    elevator_car_plant #(.NUM_FLOORS(NF), .TICKS_PER_FLOOR(T), .DOOR_TICKS(DT)) dut (
        .clk          (clk),
        .reset        (reset),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .call_btn     (call_btn),
        .current_floor(current_floor),
        .at_floor     (at_floor),
        .moving       (moving),
        .door_closed  (door_closed),
        .req          (req),
        .fault        (fault)
    );

    typedef struct {
        logic [2:0]    cf;
        logic          at, mov, dc, flt;
        logic [NF-1:0] rq;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;
    int m_pos = 0, m_tmr = 0;
    logic [2:0] m_cf = '0;
    logic m_at = 1'b1, m_mov = 1'b0, m_dc = 1'b1, m_flt = 1'b0;
    logic [NF-1:0] m_req = '0;

    task check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task step(input logic r, input logic mu, input logic md, input logic dop, input logic [NF-1:0] cb);
        exp_t e;
        logic dok, over, legal, acc;
        reset = r; motor_up = mu; motor_down = md; door_open = dop; call_btn = cb;
        if (r) begin
            m_pos = 0; m_tmr = 0; m_cf = '0; m_at = 1'b1; m_mov = 1'b0;
            m_dc = 1'b1; m_req = '0; m_flt = 1'b0;
        end else begin
            dok   = m_dc && !dop;
            over  = (mu && m_pos == (NF - 1) * T) || (md && m_pos == 0);
            legal = (mu ^ md) && dok && !over && !m_flt;
            acc   = dop && m_at && !mu && !md;
            m_req = (m_req | cb) & ~(acc ? NF'(1) << m_cf : NF'(0));
            if (FDET && ((mu && md) || over || ((mu || md) && !dok)))
                m_flt = 1'b1;
            if (acc) begin
                m_tmr = DT; m_dc = 1'b0;
            end else if (m_tmr > 0) begin
                m_tmr--;
                if (m_tmr == 0) m_dc = 1'b1;
            end
            if (legal) m_pos += mu ? 1 : -1;
            m_at = (m_pos % T) == 0;
            if (m_at) m_cf = 3'(m_pos / T);
            m_mov = legal;
        end
        e.cf = m_cf; e.at = m_at; e.mov = m_mov; e.dc = m_dc; e.rq = m_req; e.flt = m_flt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("current_floor", current_floor, e.cf);
        check("at_floor", at_floor, e.at);
        check("moving", moving, e.mov);
        check("door_closed", door_closed, e.dc);
        check("req", req, e.rq);
        check("fault", fault, e.flt);
    endtask

    task run(input int n, input logic mu, input logic md);
        for (int i = 0; i < n; i++) step(1'b0, mu, md, 1'b0, '0);
    endtask

    initial begin
        step(1'b1, 0, 0, 0, '0);
        step(1'b1, 0, 0, 0, '0);
        check("rst_floor", current_floor, 0);
        check("rst_door", door_closed, 1);
        // floor 0 to 1 in exactly TICKS_PER_FLOOR edges
        run(7, 1, 0);
        check("mid_at_floor", at_floor, 0);
        check("mid_moving", moving, 1);
        run(1, 1, 0);
        check("up_floor1", current_floor, 1);
        check("up_at1", at_floor, 1);
        run(8, 1, 0);
        // mid-floor reversal below floor 2
        run(1, 0, 1);
        check("dn_hold_floor", current_floor, 2);
        check("dn_at", at_floor, 0);
        run(1, 1, 0);
        check("rev_floor", current_floor, 2);
        check("rev_at", at_floor, 1);
        run(8, 1, 0);
        // door window at floor 3 with motor_up held throughout
        step(1'b0, 0, 0, 1, '0);
        check("door_open0", door_closed, 0);
        run(3, 1, 0);
        check("door_open3", door_closed, 0);
        run(1, 1, 0);
        check("door_shut", door_closed, 1);
        check("door_nomove", current_floor, 3);
        check("door_fault", fault, FDET);
        // call latch with clear-priority at floor 1
        step(1'b1, 0, 0, 0, '0);
        run(8, 1, 0);
        step(1'b0, 0, 0, 0, 5'b10010);
        check("req_set", req, 5'b10010);
        step(1'b0, 0, 0, 1, 5'b00010);
        check("req_clr", req, 5'b10000);
        run(5, 0, 0);
        // overtravel at the top floor
        run(24, 1, 0);
        check("top_floor", current_floor, 4);
        run(2, 1, 0);
        check("top_hold", current_floor, 4);
        check("top_nomove", moving, 0);
        check("top_fault", fault, FDET);
        // both motors at floor 0, then a legal command
        step(1'b1, 0, 0, 0, '0);
        run(1, 1, 1);
        check("both_nomove", moving, 0);
        check("both_fault", fault, FDET);
        run(3, 1, 0);
        check("after_both_moving", moving, !FDET);
        check("after_both_fault", fault, FDET);
        // reset mid-travel
        step(1'b1, 0, 0, 0, 5'b00100);
        run(13, 1, 0);
        step(1'b0, 0, 0, 0, 5'b01000);
        step(1'b1, 1, 0, 0, '0);
        check("rst_mid_floor", current_floor, 0);
        check("rst_mid_at", at_floor, 1);
        check("rst_mid_req", req, 0);
        check("rst_mid_moving", moving, 0);
        run(2, 0, 1);
        check("queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
